// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  localparam int LINE_BYTES = 16;
  localparam int OFFSET_W   = 4;
  localparam int WORD_SEL_W = 2;

  function automatic logic [31:0] line_word(input logic [LINE_BYTES*8-1:0] line,
                                            input logic [WORD_SEL_W-1:0]   sel);
    return line[{sel, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: async read at idx, sync line refill and byte-masked word write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int INDEX_W = $clog2(LINES),
  parameter int TAG_W   = 32 - INDEX_W - OFFSET_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_W-1:0]      idx,
  output logic                    rd_valid,
  output logic                    rd_dirty,
  output logic [TAG_W-1:0]        rd_tag,
  output logic [LINE_BYTES*8-1:0] rd_line,
  input  logic                    line_we,
  input  logic [TAG_W-1:0]        line_tag,
  input  logic [LINE_BYTES*8-1:0] line_data,
  input  logic                    word_we,
  input  logic [WORD_SEL_W-1:0]   word_sel,
  input  logic [31:0]             word_data,
  input  logic [3:0]              word_strb
);

  logic [LINES-1:0]          valid_r;
  logic [LINES-1:0]          dirty_r;
  logic [TAG_W-1:0]          tag_r  [LINES];
  logic [LINE_BYTES*8-1:0]   data_r [LINES];
  logic [31:0]               mask_s;
  logic [31:0]               merged_s;

  assign rd_valid = valid_r[idx];
  assign rd_dirty = dirty_r[idx];
  assign rd_tag   = tag_r[idx];
  assign rd_line  = data_r[idx];

  assign mask_s   = {{8{word_strb[3]}}, {8{word_strb[2]}}, {8{word_strb[1]}}, {8{word_strb[0]}}};
  assign merged_s = (line_word(rd_line, word_sel) & ~mask_s) | (word_data & mask_s);

  // Line state bits: refill installs a clean valid line, a store hit marks it dirty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (line_we) begin
      valid_r[idx] <= 1'b1;
      dirty_r[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_r[idx] <= 1'b1;
    end
  end

  // Tag and data storage are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_r[idx] <= line_data;
      tag_r[idx]  <= line_tag;
    end else if (word_we) begin
      data_r[idx][{word_sel, 5'd0} +: 32] <= merged_s;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate D-cache controller with line refill/evict handshake.
// Define DCACHE_STATS_EN to add hit/miss/write-back counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  input  logic [3:0]   cpu_wstrb,
  output logic [31:0]  cpu_rdata,
  output logic         stall_cache,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
  output logic [31:0]  wb_cnt
`endif
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 32 - INDEX_W - OFFSET_W;

  state_t               state_r;
  state_t               state_next_s;
  logic [TAG_W-1:0]     tag_s;
  logic [INDEX_W-1:0]   idx_s;
  logic [WORD_SEL_W-1:0] sel_s;
  logic                 rd_valid_s;
  logic                 rd_dirty_s;
  logic [TAG_W-1:0]     rd_tag_s;
  logic [127:0]         rd_line_s;
  logic                 hit_s;
  logic                 line_we_s;
  logic                 word_we_s;
  logic                 unused_addr_s;

  assign tag_s         = cpu_addr[31:INDEX_W+OFFSET_W];
  assign idx_s         = cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign sel_s         = cpu_addr[3:2];
  assign unused_addr_s = ^cpu_addr[1:0];

  assign hit_s       = cpu_req & rd_valid_s & (rd_tag_s == tag_s);
  assign stall_cache = (state_r != IDLE) | (cpu_req & ~hit_s);
  assign word_we_s   = (state_r == IDLE) & cpu_req & cpu_we & hit_s;

  dcache_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx_s),
    .rd_valid  (rd_valid_s),
    .rd_dirty  (rd_dirty_s),
    .rd_tag    (rd_tag_s),
    .rd_line   (rd_line_s),
    .line_we   (line_we_s),
    .line_tag  (tag_s),
    .line_data (mem_rdata),
    .word_we   (word_we_s),
    .word_sel  (sel_s),
    .word_data (cpu_wdata),
    .word_strb (cpu_wstrb)
  );

  // Load data is only presented on an IDLE load hit.
  always_comb begin
    cpu_rdata = 32'h0;
    if ((state_r == IDLE) && cpu_req && !cpu_we && hit_s) begin
      cpu_rdata = line_word(rd_line_s, sel_s);
    end else begin
      cpu_rdata = 32'h0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and memory handshake; request fields depend only on held inputs and state.
  always_comb begin
    state_next_s = state_r;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 128'h0;
    line_we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req && !hit_s) begin
          if (rd_valid_s && rd_dirty_s) begin
            state_next_s = WRITEBACK;
          end else begin
            state_next_s = ALLOCATE;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag_s, idx_s, 4'h0};
        mem_wdata = rd_line_s;
        if (mem_ready) begin
          state_next_s = ALLOCATE;
        end else begin
          state_next_s = WRITEBACK;
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {tag_s, idx_s, 4'h0};
        if (mem_ready) begin
          line_we_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = ALLOCATE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic replay_r;

  // Counters; the replay flag keeps the post-refill hit out of hit_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_r <= 1'b0;
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
      wb_cnt   <= 32'd0;
    end else begin
      if ((state_r == ALLOCATE) && mem_ready) begin
        replay_r <= 1'b1;
      end else if (state_r == IDLE) begin
        replay_r <= 1'b0;
      end
      if ((state_r == IDLE) && hit_s && !replay_r) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if ((state_r == IDLE) && cpu_req && !hit_s) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
      if ((state_r == WRITEBACK) && mem_ready) begin
        wb_cnt <= wb_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: architectural memory model, memory responder, directed accesses.
module tb_dcache_ctrl;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req;
  logic         cpu_we;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_wstrb;
  logic [31:0]  cpu_rdata;
  logic         stall_cache;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [31:0]  wb_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Architectural view: latest stored words; backing memory: written-back lines.
  logic [31:0]  ref_words [logic [29:0]];
  logic [127:0] mem_lines [logic [27:0]];

  // Memory transactions observed during one access.
  logic [31:0]  txn_addr  [$];
  logic         txn_we    [$];
  logic [127:0] txn_wdata [$];

  dcache_ctrl #(.LINES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_rdata   (cpu_rdata),
    .stall_cache (stall_cache),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
    .wb_cnt      (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    logic [31:0] a;
    a = {wa, 2'b00};
    if (wa[29:2] == 28'h10) begin
      case (wa[1:0])
        2'd0:    return 32'hAAAAAAAA;
        2'd1:    return 32'hBBBBBBBB;
        2'd2:    return 32'hCCCCCCCC;
        default: return 32'hDDDDDDDD;
      endcase
    end
    return a ^ 32'hC0DE0000;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    if (ref_words.exists(addr[31:2])) return ref_words[addr[31:2]];
    return init_word(addr[31:2]);
  endfunction

  function automatic logic [127:0] ref_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_read({la, w[1:0], 2'b00});
    return l;
  endfunction

  function automatic logic [127:0] mem_read(input logic [27:0] la);
    logic [127:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word({la, w[1:0]});
    return l;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: mem_ready on the LAT-th cycle of each request.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 128'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      if (rst || !mem_req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == LAT) begin
          cnt = 0;
          mem_ready = 1'b1;
          if (mem_we) begin
            chk("wb_line_data", mem_wdata, ref_line(mem_addr[31:4]));
            mem_lines[mem_addr[31:4]] = mem_wdata;
          end else begin
            mem_rdata = mem_read(mem_addr[31:4]);
          end
        end
      end
    end
  end

  // Per-cycle compare against the architectural model and handshake rules.
  initial begin
    logic         have_prev;
    logic         prev_req, prev_ready, prev_we;
    logic [31:0]  prev_addr;
    logic [127:0] prev_wdata;
    logic [31:0]  w;
    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_prev = 1'b0;
      end else begin
        if (cpu_req && !cpu_we && !stall_cache)
          chk("load_data", {96'h0, cpu_rdata}, {96'h0, ref_read(cpu_addr)});
        else
          chk("rdata_zero", {96'h0, cpu_rdata}, 128'h0);
        if (!cpu_req) chk("stall_without_req", {127'h0, stall_cache}, 128'h0);
        if (cpu_req && cpu_we && !stall_cache) begin
          w = ref_read(cpu_addr);
          for (int b = 0; b < 4; b++)
            if (cpu_wstrb[b]) w[b*8 +: 8] = cpu_wdata[b*8 +: 8];
          ref_words[cpu_addr[31:2]] = w;
        end
        if (have_prev && prev_req && !prev_ready) begin
          chk("req_held",   {127'h0, mem_req}, 128'h1);
          chk("addr_held",  {96'h0, mem_addr}, {96'h0, prev_addr});
          chk("we_held",    {127'h0, mem_we}, {127'h0, prev_we});
          chk("wdata_held", mem_wdata, prev_wdata);
        end
        if (mem_req) begin
          chk("addr_align", {124'h0, mem_addr[3:0]}, 128'h0);
          chk("mem_index", {124'h0, mem_addr[7:4]}, {124'h0, cpu_addr[7:4]});
          if (!mem_we) chk("fetch_line", {100'h0, mem_addr[31:4]}, {100'h0, cpu_addr[31:4]});
        end
        prev_req   = mem_req;
        prev_ready = mem_ready;
        prev_we    = mem_we;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        have_prev  = 1'b1;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output int stalls);
    @(posedge clk);
    #1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = strb;
    txn_addr.delete();
    txn_we.delete();
    txn_wdata.delete();
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_req && (txn_addr.size() == 0 || txn_addr[$] != mem_addr || txn_we[$] != mem_we)) begin
        txn_addr.push_back(mem_addr);
        txn_we.push_back(mem_we);
        txn_wdata.push_back(mem_wdata);
      end
      if (!stall_cache) break;
      stalls++;
      if (i == 99) begin
        checks++;
        errors++;
        $display("FAIL access_timeout: addr %0h still stalled after %0d cycles, required release", addr, stalls);
      end
    end
  endtask

  task automatic chk_txn(input string name, input int n, input logic we, input logic [31:0] addr);
    if (txn_addr.size() > n) begin
      chk({name, "_addr"}, {96'h0, txn_addr[n]}, {96'h0, addr});
      chk({name, "_we"}, {127'h0, txn_we[n]}, {127'h0, we});
    end else begin
      chk({name, "_present"}, 128'(txn_addr.size()), 128'(n + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", {127'h0, stall_cache}, 128'h0);
    chk("reset_mem_req", {127'h0, mem_req}, 128'h0);
    chk("reset_rdata", {96'h0, cpu_rdata}, 128'h0);

    // Cold load miss, clean refill
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, n);
    chk("cold_stalls", 128'(n), 128'd4);
    chk("cold_txn_count", 128'(txn_addr.size()), 128'd1);
    chk_txn("cold_alloc", 0, 1'b0, 32'h0000_0100);
    chk("cold_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hBBBBBBBB});

    // Store hit with partial strobe, then read back
    access(1'b1, 32'h0000_0104, 32'h12345678, 4'b0011, n);
    chk("store_hit_stalls", 128'(n), 128'd0);
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, n);
    chk("load_hit_stalls", 128'(n), 128'd0);
    chk("merged_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hBBBB5678});

    // Conflict miss on a dirty line: write-back then refill
    access(1'b0, 32'h0000_0204, 32'h0, 4'h0, n);
    chk("dirty_miss_stalls", 128'(n), 128'd7);
    chk("dirty_txn_count", 128'(txn_addr.size()), 128'd2);
    chk_txn("dirty_wb", 0, 1'b1, 32'h0000_0100);
    chk_txn("dirty_alloc", 1, 1'b0, 32'h0000_0200);
    if (txn_wdata.size() > 0) chk("wb_word1", {96'h0, txn_wdata[0][63:32]}, {96'h0, 32'hBBBB5678});
    chk("dirty_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hC0DE0204});

    // Conflict miss on a clean line: no write-back
    access(1'b0, 32'h0000_0304, 32'h0, 4'h0, n);
    chk("clean_miss_stalls", 128'(n), 128'd4);
    chk("clean_txn_count", 128'(txn_addr.size()), 128'd1);
    chk_txn("clean_alloc", 0, 1'b0, 32'h0000_0300);
    chk("clean_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hC0DE0304});
`ifdef DCACHE_STATS_EN
    chk("stat_hits", {96'h0, hit_cnt}, 128'd2);
    chk("stat_misses", {96'h0, miss_cnt}, 128'd3);
    chk("stat_wbs", {96'h0, wb_cnt}, 128'd1);
`endif

    // Store miss: write-allocate, then the store lands in the refilled line
    access(1'b1, 32'h0000_0408, 32'hA5A5A5A5, 4'b1000, n);
    chk("store_miss_stalls", 128'(n), 128'd4);
    chk_txn("store_alloc", 0, 1'b0, 32'h0000_0400);
    access(1'b0, 32'h0000_0408, 32'h0, 4'h0, n);
    chk("store_miss_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hA5DE0408});

    access(1'b0, 32'h0000_1004, 32'h0, 4'h0, n);
    chk("evict2_stalls", 128'(n), 128'd7);
    chk_txn("evict2_wb", 0, 1'b1, 32'h0000_0400);
    if (txn_wdata.size() > 0) chk("wb2_word2", {96'h0, txn_wdata[0][95:64]}, {96'h0, 32'hA5DE0408});
    chk("evict2_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hC0DE1004});

    // Other index is independent; word 0 and word 3 selects
    access(1'b0, 32'h0000_0010, 32'h0, 4'h0, n);
    chk("idx1_stalls", 128'(n), 128'd4);
    chk("idx1_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hC0DE0010});
    access(1'b0, 32'h0000_100C, 32'h0, 4'h0, n);
    chk("word3_stalls", 128'(n), 128'd0);
    chk("word3_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hC0DE100C});

    // Reset while ALLOCATE is in flight
    @(posedge clk);
    #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2004;
    @(posedge clk);
    #1;
    chk("pre_rst_mem_req", {127'h0, mem_req}, 128'h1);
    chk("pre_rst_mem_we", {127'h0, mem_we}, 128'h0);
    #2;
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rst_mem_req", {127'h0, mem_req}, 128'h0);
    chk("rst_stall", {127'h0, stall_cache}, 128'h0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    access(1'b0, 32'h0000_100C, 32'h0, 4'h0, n);
    chk("post_rst_stalls", 128'(n), 128'd4);
    chk("post_rst_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hC0DE100C});
    access(1'b0, 32'h0000_0104, 32'h0, 4'h0, n);
    chk("post_rst_104_stalls", 128'(n), 128'd4);
    chk("post_rst_104_rdata", {96'h0, cpu_rdata}, {96'h0, 32'hBBBB5678});

    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
